// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parametrised IEEE-754-style multiplier, round-to-nearest-even, subnormals flushed to zero.
// Latency: 5 cycles from acceptance to valid_out; one result per cycle when not stalled.
// Backpressure: a held result (valid_out && !ready_in) freezes every stage and drops ready_out.
`timescale 1ns/1ps
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [EXP_W+FRAC_W:0] a_in,
    input  logic [EXP_W+FRAC_W:0] b_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [EXP_W+FRAC_W:0] c_out,
    output logic [3:0]            flags_out
);

    localparam int MW  = FRAC_W + 1;          // mantissa width incl. hidden bit
    localparam int PW  = 2 * FRAC_W + 2;      // full product width
    localparam int EW2 = EXP_W + 2;           // signed working exponent width

    localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic [FRAC_W-1:0]     FRAC_QNAN = {1'b1, {(FRAC_W-1){1'b0}}};

    // Special-case class decided at the input and carried down the pipe.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } special_e;

    // A single stall condition drives every stage so bubbles stay in place.
    logic w_en;
    assign w_en      = !(valid_out && !ready_in);
    assign ready_out = w_en;

    // ---------------- S1: classify operands ----------------
    logic              w_a_sign, w_b_sign;
    logic [EXP_W-1:0]  w_a_exp,  w_b_exp;
    logic [FRAC_W-1:0] w_a_frac, w_b_frac;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    special_e          w_sp1;

    assign w_a_sign = a_in[EXP_W+FRAC_W];
    assign w_b_sign = b_in[EXP_W+FRAC_W];
    assign w_a_exp  = a_in[EXP_W+FRAC_W-1:FRAC_W];
    assign w_b_exp  = b_in[EXP_W+FRAC_W-1:FRAC_W];
    assign w_a_frac = a_in[FRAC_W-1:0];
    assign w_b_frac = b_in[FRAC_W-1:0];

    // exp==0 covers true zero and flushed subnormals alike.
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (w_a_exp == EXP_ONES) && (w_a_frac == '0);
    assign w_b_inf  = (w_b_exp == EXP_ONES) && (w_b_frac == '0);
    assign w_a_nan  = (w_a_exp == EXP_ONES) && (w_a_frac != '0);
    assign w_b_nan  = (w_b_exp == EXP_ONES) && (w_b_frac != '0);

    // Priority: NaN / Inf*0 first, then Inf, then zero.
    always_comb begin
        w_sp1 = SP_NONE;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf))
            w_sp1 = SP_NAN;
        else if (w_a_inf || w_b_inf)
            w_sp1 = SP_INF;
        else if (w_a_zero || w_b_zero)
            w_sp1 = SP_ZERO;
    end

    logic              r_v1;
    logic              r_s1;
    logic [EXP_W-1:0]  r_ea1, r_eb1;
    logic [MW-1:0]     r_ma1, r_mb1;
    special_e          r_sp1;

    // S1 register: operand fields with hidden bit restored, plus special class.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_v1 <= 1'b0;
        else if (w_en)
            r_v1 <= valid_in;
        if (w_en) begin
            r_s1  <= w_a_sign ^ w_b_sign;
            r_ea1 <= w_a_exp;
            r_eb1 <= w_b_exp;
            r_ma1 <= {1'b1, w_a_frac};
            r_mb1 <= {1'b1, w_b_frac};
            r_sp1 <= w_sp1;
        end
    end

    // ---------------- S2: multiply, exponent sum ----------------
    logic                  r_v2;
    logic                  r_s2;
    logic [PW-1:0]         r_prod2;
    logic signed [EW2-1:0] r_e2;
    special_e              r_sp2;

    // S2 register: full-width mantissa product and biased exponent sum.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_v2 <= 1'b0;
        else if (w_en)
            r_v2 <= r_v1;
        if (w_en) begin
            r_s2    <= r_s1;
            r_prod2 <= PW'(r_ma1) * PW'(r_mb1);
            r_e2    <= $signed({2'b00, r_ea1}) + $signed({2'b00, r_eb1}) - BIAS;
            r_sp2   <= r_sp1;
        end
    end

    // ---------------- S3: normalise ----------------
    // Product of two [1,2) mantissas lies in [1,4); at most one right shift needed.
    logic                  w_hi;
    logic [FRAC_W-1:0]     w_f3;
    logic                  w_g3, w_st3;
    logic signed [EW2-1:0] w_e3;

    assign w_hi = r_prod2[PW-1];

    // Pick the fraction window plus guard and sticky for the chosen alignment.
    always_comb begin
        w_f3  = r_prod2[PW-3 -: FRAC_W];
        w_g3  = r_prod2[FRAC_W-1];
        w_st3 = |r_prod2[FRAC_W-2:0];
        if (w_hi) begin
            w_f3  = r_prod2[PW-2 -: FRAC_W];
            w_g3  = r_prod2[FRAC_W];
            w_st3 = |r_prod2[FRAC_W-1:0];
        end
    end

    assign w_e3 = r_e2 + $signed(EW2'(w_hi));

    logic                  r_v3;
    logic                  r_s3;
    logic [FRAC_W-1:0]     r_f3;
    logic                  r_g3, r_st3;
    logic signed [EW2-1:0] r_e3;
    special_e              r_sp3;

    // S3 register: normalised fraction, rounding bits and adjusted exponent.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_v3 <= 1'b0;
        else if (w_en)
            r_v3 <= r_v2;
        if (w_en) begin
            r_s3  <= r_s2;
            r_f3  <= w_f3;
            r_g3  <= w_g3;
            r_st3 <= w_st3;
            r_e3  <= w_e3;
            r_sp3 <= r_sp2;
        end
    end

    // ---------------- S4: round to nearest even ----------------
    logic              w_rup4;
    logic [FRAC_W:0]   w_fsum4;
    logic              w_carry4;

    // Round up above half, or on an exact half when the kept LSB is odd.
    assign w_rup4   = r_g3 & (r_st3 | r_f3[0]);
    assign w_fsum4  = {1'b0, r_f3} + (FRAC_W+1)'(w_rup4);
    assign w_carry4 = w_fsum4[FRAC_W];

    logic                  r_v4;
    logic                  r_s4;
    logic [FRAC_W-1:0]     r_f4;
    logic signed [EW2-1:0] r_e4;
    logic                  r_inx4;
    special_e              r_sp4;

    // S4 register: rounded fraction; a carry-out leaves the fraction at zero and bumps e.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_v4 <= 1'b0;
        else if (w_en)
            r_v4 <= r_v3;
        if (w_en) begin
            r_s4   <= r_s3;
            r_f4   <= w_fsum4[FRAC_W-1:0];
            r_e4   <= r_e3 + $signed(EW2'(w_carry4));
            r_inx4 <= r_g3 | r_st3;
            r_sp4  <= r_sp3;
        end
    end

    // ---------------- S5: pack result and flags ----------------
    logic [EXP_W+FRAC_W:0] w_c5;
    logic [3:0]            w_flags5;
    logic                  w_e4_low;

    // Non-positive exponent: no subnormal output, the result flushes to zero.
    assign w_e4_low = r_e4[EW2-1] || (r_e4 == '0);

    // Select special result, overflow, underflow or the normal packed value.
    always_comb begin
        w_c5     = {r_s4, r_e4[EXP_W-1:0], r_f4};
        w_flags5 = {3'b000, r_inx4};
        case (r_sp4)
            SP_NAN: begin
                w_c5     = {1'b0, EXP_ONES, FRAC_QNAN};
                w_flags5 = 4'b1000;
            end
            SP_INF: begin
                w_c5     = {r_s4, EXP_ONES, {FRAC_W{1'b0}}};
                w_flags5 = 4'b0000;
            end
            SP_ZERO: begin
                w_c5     = {r_s4, {(EXP_W+FRAC_W){1'b0}}};
                w_flags5 = 4'b0000;
            end
            default: begin
                if (r_e4 >= EXP_MAX) begin
                    w_c5     = {r_s4, EXP_ONES, {FRAC_W{1'b0}}};
                    w_flags5 = 4'b0101;
                end else if (w_e4_low) begin
                    w_c5     = {r_s4, {(EXP_W+FRAC_W){1'b0}}};
                    w_flags5 = 4'b0011;
                end
            end
        endcase
    end

    // S5 register: output stage, the only one whose data is cleared by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            c_out     <= '0;
            flags_out <= 4'b0000;
        end else if (w_en) begin
            valid_out <= r_v4;
            c_out     <= w_c5;
            flags_out <= w_flags5;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: checks fp32 and bf16 instances of fp_mul_pipe against an arithmetic model.
// Latency: directed ops verify the exact 5-cycle latency; streams use a scoreboard.
// Backpressure: both instances share valid_in/ready_in so they stall identically.
`timescale 1ns/1ps
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] a32, b32, c32;
    logic [3:0]  f32;
    logic        rdy32, vo32;
    logic [15:0] a16, b16, c16;
    logic [3:0]  f16;
    logic        rdy16, vo16;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out32  = 0;
    int n_stall  = 0;

    logic [35:0] q32[$];
    logic [35:0] q16[$];

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut32 (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_out(rdy32),
        .a_in(a32), .b_in(b32), .valid_out(vo32), .ready_in(ready_in),
        .c_out(c32), .flags_out(f32)
    );

    fp_mul_pipe #(.EXP_W(8), .FRAC_W(7)) dut16 (
        .clk_in(clk), .rst_in(rst), .valid_in(valid_in), .ready_out(rdy16),
        .a_in(a16), .b_in(b16), .valid_out(vo16), .ready_in(ready_in),
        .c_out(c16), .flags_out(f16)
    );

    // Reference: exact integer product, rounded by comparing the discarded remainder to one half.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int ew, input int fw);
        longint emax, bias, fmask, ea, eb, fa, fb, p, q, rem, half, e;
        int sh;
        logic sa, sb, s, za, zb, ia, ib, na, nb;
        logic [31:0] c;
        logic [3:0] fl;
        emax  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        fmask = (longint'(1) << fw) - 1;
        ea = (longint'(a) >> fw) & emax;
        eb = (longint'(b) >> fw) & emax;
        fa = longint'(a) & fmask;
        fb = longint'(b) & fmask;
        sa = a[ew+fw];
        sb = b[ew+fw];
        s  = sa ^ sb;
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        fl = 4'b0000;
        if (na || nb || (ia && zb) || (za && ib)) begin
            c  = 32'((emax << fw) | (longint'(1) << (fw - 1)));
            fl = 4'b1000;
        end else if (ia || ib) begin
            c = 32'((longint'(s) << (ew + fw)) | (emax << fw));
        end else if (za || zb) begin
            c = 32'(longint'(s) << (ew + fw));
        end else begin
            p = ((longint'(1) << fw) | fa) * ((longint'(1) << fw) | fb);
            e = ea + eb - bias;
            if (p >= (longint'(1) << (2 * fw + 1))) begin
                sh = fw + 1;
                e  = e + 1;
            end else begin
                sh = fw;
            end
            q    = p >> sh;
            rem  = p & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1))
                q = q + 1;
            if (q == (longint'(1) << (fw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                c  = 32'((longint'(s) << (ew + fw)) | (emax << fw));
                fl = 4'b0101;
            end else if (e <= 0) begin
                c  = 32'(longint'(s) << (ew + fw));
                fl = 4'b0011;
            end else begin
                c  = 32'((longint'(s) << (ew + fw)) | (e << fw) | (q & fmask));
                fl = {3'b000, rem != 0};
            end
        end
        return {fl, c};
    endfunction

    // Random operand biased towards specials and exponents near the bias.
    function automatic logic [31:0] rnd_op(input int ew, input int fw);
        logic [31:0] s, e, f;
        int emax, bias;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        f = $urandom & ((32'd1 << fw) - 1);
        s = 32'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0:       e = 32'd0;
            1:       e = 32'(emax);
            2:       begin e = 32'(emax); f = 32'd0; end
            3, 4, 5: e = 32'($urandom_range(1, emax - 1));
            default: e = 32'($urandom_range(bias - 12, bias + 12));
        endcase
        return (s << (ew + fw)) | (e << fw) | f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated op into an empty pipe: exact latency and both results.
    task automatic do_op(input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic [3:0] ef,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] ec16, input logic [3:0] ef16);
        valid_in = 1'b1;
        a32 = a; b32 = b; a16 = x; b16 = y;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_early_vld"}, 32'(vo32), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld32"},   32'(vo32), 32'd1);
        chk({tag, "_c32"},     c32,       ec);
        chk({tag, "_flags32"}, 32'(f32),  32'(ef));
        chk({tag, "_vld16"},   32'(vo16), 32'd1);
        chk({tag, "_c16"},     32'(c16),  32'(ec16));
        chk({tag, "_flags16"}, 32'(f16),  32'(ef16));
        @(posedge clk); #1;
    endtask

    task automatic do_op_ref(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [15:0] x, input logic [15:0] y);
        logic [35:0] r, r16;
        r   = ref_mul(a, b, 8, 23);
        r16 = ref_mul({16'h0, x}, {16'h0, y}, 8, 7);
        do_op(tag, a, b, r[31:0], r[35:32], x, y, r16[15:0], r16[35:32]);
    endtask

    // One streaming cycle: handshake check, scoreboard push on accept, pop on transfer out.
    task automatic tick(output bit acc);
        logic [35:0] e;
        @(negedge clk);
        chk("ready_out32", 32'(rdy32), 32'(!(vo32 && !ready_in)));
        chk("ready_out16", 32'(rdy16), 32'(!(vo16 && !ready_in)));
        acc = valid_in && rdy32;
        if (acc) q32.push_back(ref_mul(a32, b32, 8, 23));
        if (valid_in && rdy16) q16.push_back(ref_mul({16'h0, a16}, {16'h0, b16}, 8, 7));
        if (!rdy32) n_stall++;
        if (vo32 && ready_in) begin
            n_out32++;
            chk("out32_expected", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                chk("stream_c32",     c32,      e[31:0]);
                chk("stream_flags32", 32'(f32), 32'(e[35:32]));
            end
        end
        if (vo16 && ready_in) begin
            chk("out16_expected", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("stream_c16",     32'(c16), 32'(e[15:0]));
                chk("stream_flags16", 32'(f16), 32'(e[35:32]));
            end
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] kv [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        bit          acc;
        int          k, out0, stall0;
        logic [31:0] t;

        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld32",   32'(vo32), 32'd0);
        chk("rst_c32",     c32,       32'd0);
        chk("rst_flags32", 32'(f32),  32'd0);
        chk("rst_vld16",   32'(vo16), 32'd0);
        chk("rst_c16",     32'(c16),  32'd0);
        chk("rst_rdy32",   32'(rdy32), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors with hand-derived results
        do_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000,
              16'h3FC0, 16'h4000, 16'h4040, 4'b0000);
        do_op("tie_odd",   32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001,
              16'h7F80, 16'h0000, 16'h7FC0, 4'b1000);
        do_op("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000,
              16'hFF80, 16'h4000, 16'hFF80, 4'b0000);
        do_op("overflow",  32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101,
              16'h7F00, 16'h7F00, 16'h7F80, 4'b0101);
        do_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011,
              16'h0080, 16'h3F00, 16'h0000, 4'b0011);
        do_op("neg_zero",  32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000,
              16'hC000, 16'h0001, 16'h8000, 4'b0000);
        do_op("nan_sign",  32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000,
              16'hFF81, 16'h0000, 16'h7FC0, 4'b1000);

        // Backpressure: 1.0 x k, k=1..8, output stalled on cycles 6-9
        k = 0; out0 = n_out32; stall0 = n_stall;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            ready_in = !(cyc >= 6 && cyc <= 9);
            if (k < 8) begin
                valid_in = 1'b1;
                a32 = 32'h3F800000; b32 = kv[k];
                t = kv[k];
                a16 = 16'h3F80; b16 = t[31:16];
            end else begin
                valid_in = 1'b0;
            end
            tick(acc);
            k += int'(acc);
        end
        chk("bp_accepted", 32'(k), 32'd8);
        chk("bp_outputs",  32'(n_out32 - out0), 32'd8);
        chk("bp_stalls",   32'(n_stall - stall0), 32'd4);
        chk("bp_q32_empty", 32'(q32.size()), 32'd0);
        chk("bp_q16_empty", 32'(q16.size()), 32'd0);

        // Reset with three ops in flight
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            a32 = rnd_op(8, 23); b32 = rnd_op(8, 23);
            t = rnd_op(8, 7); a16 = t[15:0];
            t = rnd_op(8, 7); b16 = t[15:0];
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld32", 32'(vo32), 32'd0);
        chk("midrst_vld16", 32'(vo16), 32'd0);
        chk("midrst_c32",   c32,       32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_stale32", 32'(vo32), 32'd0);
            chk("no_stale16", 32'(vo16), 32'd0);
        end
        @(posedge clk); #1;
        do_op_ref("after_rst", 32'h40490FDB, 32'hBFC00000, 16'h4049, 16'hBFC0);

        // Random directed singles
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb, rx, ry;
            ra = rnd_op(8, 23); rb = rnd_op(8, 23);
            rx = rnd_op(8, 7);  ry = rnd_op(8, 7);
            do_op_ref("rand_single", ra, rb, rx[15:0], ry[15:0]);
        end

        // Random stream with random valid and ready
        for (int cyc = 0; cyc < 400; cyc++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 3) != 0);
            a32 = rnd_op(8, 23); b32 = rnd_op(8, 23);
            t = rnd_op(8, 7); a16 = t[15:0];
            t = rnd_op(8, 7); b16 = t[15:0];
            tick(acc);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) tick(acc);
        chk("rand_q32_empty", 32'(q32.size()), 32'd0);
        chk("rand_q16_empty", 32'(q16.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the graphics datapath (vertex transform, shading).
- Generalises the fixed fp32 multiplier to arbitrary exponent and fraction widths, e.g. fp32 or bf16.
- Adds round-to-nearest-even, correct NaN/Inf/zero handling, exception flags and ready/valid backpressure.
- Drop-in unit inside matrix/vector pipelines that may stall downstream.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
FRAC_W, 23, stored fraction width (hidden bit excluded)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
valid_in  input  1  operand pair valid
ready_out  output  1  block can accept operands this cycle
a_in  input  1+EXP_W+FRAC_W  operand A {sign, exp, frac}
b_in  input  1+EXP_W+FRAC_W  operand B
valid_out  output  1  result valid
ready_in  input  1  downstream accepts result
c_out  output  1+EXP_W+FRAC_W  product
flags_out  output  4  {invalid, overflow, underflow, inexact}, qualified by valid_out

Behaviour:
- One clock (clk_in). Reset is synchronous, active-high (rst_in).
- Reset clears all stage valid bits. valid_out=0, c_out=0, flags_out=0. Data registers need no reset. Reset mid-operation discards all in-flight results.
- Pipeline of 5 stages; LATENCY = 5 cycles from acceptance to valid_out, absent stalls.
  - S1: register and classify operands.
  - S2: multiply (FRAC_W+1)x(FRAC_W+1) and form exponent sum.
  - S3: normalise.
  - S4: round.
  - S5: pack result and flags.
- Handshake:
  - Global enable en = !(valid_out && !ready_in). ready_out = en.
  - Transfer in when valid_in && ready_out. Transfer out when valid_out && ready_in.
  - When en=0, every stage holds its data and valid bit. Bubbles are not compressed.
  - Full throughput: 1 op/cycle while ready_in=1.
- Classification:
  - exp=0 means zero. Subnormals are flushed to zero, sign kept.
  - exp=all-ones, frac=0 means Inf. exp=all-ones, frac!=0 means NaN.
- Result sign = a_sign ^ b_sign, except for NaN.
- Special cases, in priority order:
  - Any NaN operand, or Inf x zero: canonical NaN (sign 0, exp all-ones, frac MSB 1, rest 0); invalid=1.
  - Inf x nonzero: signed Inf; no flags.
  - Zero x finite: signed zero; no flags.
- Arithmetic:
  - Exponent computed at EXP_W+2 bits signed: e = ea + eb - bias.
  - Product is 2*FRAC_W+2 bits. If MSB is set, shift right 1 and e+1.
  - Round to nearest even using guard bit and sticky OR of the remaining bits. inexact = guard|sticky.
  - Rounding carry-out renormalises: fraction becomes 0, e+1.
- After rounding:
  - e >= 2^EXP_W-1: signed Inf; overflow=1, inexact=1.
  - e <= 0: signed zero (flush, no subnormal output); underflow=1, inexact=1.
  - Otherwise pack normally.
- flags_out is meaningful only when valid_out=1.

Test Plan:
- fp32, 0x3FC00000 x 0x40000000 -> after 5 cycles valid_out=1, c_out=0x40400000, flags=0000.
- fp32, 0x3FC00000 x 0x3F800001 (exact tie, odd LSB) -> c_out=0x3FC00002, flags=0001; also 0x7F800000 x 0x00000000 -> 0x7FC00000, flags=1000.
- fp32 edge cases:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000, flags=0101.
  - 0x00800000 x 0x3F000000 -> 0x00000000, flags=0011.
  - 0xC0000000 x 0x00000000 -> 0x80000000, flags=0000.
- fp32 backpressure:
  - Stream 8 back-to-back ops (1.0 x k, k=1..8) with ready_in low on cycles 6-9.
  - Required: all 8 results in order, none lost or duplicated.
  - ready_out=0 exactly while valid_out && !ready_in.
- Assert rst_in for one cycle while 3 ops are in flight -> valid_out=0 the next cycle; no stale result ever emerges; a new op then returns after exactly 5 cycles.
- EXP_W=8, FRAC_W=7 (bf16): 0x3FC0 x 0x4000 -> 0x4040; 0x7F80 x 0x0000 -> 0x7FC0, invalid=1.
